// File: rtl/bram_mem_be.sv
// bram_mem_be: simple dual-port RAM (one write, one read) with byte enables.
//
// Pipeline:
//   stage 1  registers the user write/read request every cycle (dropped while clearing)
//   stage 2  performs the array write and the synchronous array read
//   stage 3  optional output register (OUT_REG=1)
// Read latency from ren sampled to rvalid visible: 2 + OUT_REG cycles.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wen/waddr/wdata   write request, address, data
//   wbe               byte enables, bit b gates wdata[8b+7:8b]
//   ren/raddr         read request and address
//   rdata/rvalid      read data and its qualifier; rdata holds while rvalid=0
//   clr_start         pulse that starts zeroing the whole array
//   clr_busy          clear engine active; user requests are dropped meanwhile
//
// The array has no reset; an aborted clear leaves the untouched words as they were.

module bram_mem_be #(
    parameter int unsigned DATAW    = 32,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned ADDRW    = $clog2(DEPTH),
    parameter int unsigned NBYTES   = DATAW / 8,
    parameter int unsigned OUT_REG  = 1,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDRW-1:0]  waddr,
    input  logic [DATAW-1:0]  wdata,
    input  logic [NBYTES-1:0] wbe,
    input  logic              ren,
    input  logic [ADDRW-1:0]  raddr,
    output logic [DATAW-1:0]  rdata,
    output logic              rvalid,
    input  logic              clr_start,
    output logic              clr_busy
);

    typedef enum logic {StIdle, StClear} clr_state_e;

    logic [DATAW-1:0] mem [DEPTH];

    clr_state_e       state_q, state_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;

    // Stage 1 request registers
    logic              wen_q;
    logic [ADDRW-1:0]  waddr_q;
    logic [DATAW-1:0]  wdata_q;
    logic [NBYTES-1:0] wbe_q;
    logic              ren_q;
    logic [ADDRW-1:0]  raddr_q;

    // Shared array write port (clear engine or user)
    logic              mem_we;
    logic [ADDRW-1:0]  mem_wa;
    logic [DATAW-1:0]  mem_wd;
    logic [NBYTES-1:0] mem_be;

    logic              wr_in_range;
    logic              rd_in_range;
    logic [DATAW-1:0]  rd_old;
    logic [DATAW-1:0]  rd_word;

    // Stage 2 read result
    logic [DATAW-1:0]  rdata2_q;
    logic              rvalid2_q;

    assign clr_busy = (state_q == StClear);

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                // clr_start is ignored here: a running clear is never restarted
                if (cnt_q == ADDRW'(DEPTH - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: register user requests, dropping them while clearing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wbe_q   <= '0;
            ren_q   <= 1'b0;
            raddr_q <= '0;
        end else begin
            wen_q   <= wen & ~clr_busy;
            waddr_q <= waddr;
            wdata_q <= wdata;
            wbe_q   <= wbe;
            ren_q   <= ren & ~clr_busy;
            raddr_q <= raddr;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: array write and read
    // ------------------------------------------------------------------
    assign wr_in_range = 32'(waddr_q) < DEPTH;
    assign rd_in_range = 32'(raddr_q) < DEPTH;

    // The clear owns the port while active. A user write accepted in the clr_start cycle
    // lands on the first clear edge and is superseded; the clear zeroes every word anyway.
    always_comb begin
        mem_we = wen_q && wr_in_range && (wbe_q != '0);
        mem_wa = waddr_q;
        mem_wd = wdata_q;
        mem_be = wbe_q;
        if (state_q == StClear) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = '0;
            mem_be = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (mem_be[b]) begin
                    mem[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
                end
            end
        end
    end

    // Same-address write in the same cycle: old word unless RDW_MODE selects forwarding
    always_comb begin
        rd_old  = rd_in_range ? mem[raddr_q] : '0;
        rd_word = rd_old;
        if ((RDW_MODE != 0) && mem_we && rd_in_range && (mem_wa == raddr_q)) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (mem_be[b]) begin
                    rd_word[8*b +: 8] = mem_wd[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata2_q  <= '0;
            rvalid2_q <= 1'b0;
        end else begin
            rvalid2_q <= ren_q;
            if (ren_q) begin
                rdata2_q <= rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: optional output register
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATAW-1:0] rdata3_q;
        logic             rvalid3_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata3_q  <= '0;
                rvalid3_q <= 1'b0;
            end else begin
                rvalid3_q <= rvalid2_q;
                if (rvalid2_q) begin
                    rdata3_q <= rdata2_q;
                end
            end
        end

        assign rdata  = rdata3_q;
        assign rvalid = rvalid3_q;
    end else begin : g_no_out_reg
        assign rdata  = rdata2_q;
        assign rvalid = rvalid2_q;
    end

endmodule
